// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: front end for pe_module.
// Holds a 3x3 kernel and buffers pixels in a small FIFO.
// On go it pulses start once, then streams one pixel per cycle.
// Each pixel is paired with one kernel column (0,1,2 rotating).
// Optional build macro PE_FEEDER_STALL_CNT_EN adds a stall_cnt output.
// stall_cnt counts STREAM cycles that found the FIFO empty.
module pe_stream_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             k_wr_en,
  input  logic [3:0]       k_wr_addr,
  input  logic [7:0]       k_wr_data,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  input  logic             go,
  input  logic [LEN_W-1:0] num_pixels,
  input  logic [2:0]       channel_in,
  output logic             busy,
  output logic             start,
  output logic             out_valid,
  output logic [7:0]       weight1,
  output logic [7:0]       weight2,
  output logic [7:0]       weight3,
  output logic [7:0]       img,
  output logic [2:0]       channel_packed,
  output logic             done
`ifdef PE_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_DONE} state_t;

  // One output beat as presented to the PE.
  typedef struct packed {
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] w3;
    logic [7:0] px;
  } beat_t;

  state_t state, nxt;

  // ---------------- pixel FIFO ----------------
  logic [FIFO_DEPTH-1:0][7:0] fifo_mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                occ;
  logic                       full, empty, push, pop;
  logic [7:0]                 head;

  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);
  assign pix_ready = !full;
  assign push      = pix_valid && pix_ready;
  assign pop       = (state == S_STREAM) && !empty;
  assign head      = fifo_mem[rd_ptr];

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pix_data;
  end

  // FIFO pointers and occupancy; push and pop together leave occ unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // ---------------- kernel registers ----------------
  logic [8:0][7:0] kern;

  // Kernel writes only land while idle so a running job sees a stable kernel.
  always_ff @(posedge clk) begin
    if (reset) begin
      kern <= '0;
    end else if (state == S_IDLE && k_wr_en && k_wr_addr <= 4'd8) begin
      kern[k_wr_addr] <= k_wr_data;
    end
  end

  // ---------------- job bookkeeping ----------------
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [1:0]       col_q;
  logic [3:0]       idx1, idx2, idx3;
  logic             last_pop;
  beat_t            beat_d, beat_q;

  assign idx1     = {2'b00, col_q};
  assign idx2     = idx1 + 4'd3;
  assign idx3     = idx1 + 4'd6;
  assign last_pop = pop && (cnt_q == len_q - 1'b1);

  // Weights are read live from the kernel for the current column.
  always_comb begin
    beat_d.w1 = kern[idx1];
    beat_d.w2 = kern[idx2];
    beat_d.w3 = kern[idx3];
    beat_d.px = head;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state and control outputs; go is only honoured while idle.
  always_comb begin
    nxt   = state;
    busy  = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) nxt = (num_pixels != '0) ? S_START : S_DONE;
      end
      S_START: begin
        start = 1'b1;
        busy  = 1'b1;
        nxt   = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (last_pop) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Job length, channel tag, column/count tracking and registered beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q          <= '0;
      cnt_q          <= '0;
      col_q          <= '0;
      channel_packed <= '0;
      out_valid      <= 1'b0;
      beat_q         <= '0;
    end else begin
      if (state == S_IDLE && go) begin
        len_q          <= num_pixels;
        channel_packed <= channel_in;
      end
      if (state == S_START) begin
        col_q <= '0;
        cnt_q <= '0;
      end
      out_valid <= pop;
      if (pop) begin
        beat_q <= beat_d;
        col_q  <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign weight1 = beat_q.w1;
  assign weight2 = beat_q.w2;
  assign weight3 = beat_q.w3;
  assign img     = beat_q.px;

`ifdef PE_FEEDER_STALL_CNT_EN
  // Saturating count of empty-FIFO stream cycles; kept after done for readout.
  always_ff @(posedge clk) begin
    if (reset || state == S_START) begin
      stall_cnt <= '0;
    end else if (state == S_STREAM && empty && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
